// File: rtl/jk_count_sequencer.sv
// Command-driven sequencer for a bank of JK flip-flops operated as a modulo-MOD
// register/counter; the per-bit J/K drive is exported alongside the bank contents.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready=1, bank held
// EXEC   | one-cycle LOAD or CLEAR drive of the bank
// STEP   | one modulo count per cycle until remaining reaches zero
// DONE   | one-cycle done pulse, then back to IDLE
module jk_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] j_drv, k_drv;
  logic [WIDTH-1:0] q_inc, q_dec, q_target, load_val;
  logic             step_wrap;

  // Neighbours of q within 0..MOD-1; the wrap points are explicit so a
  // modulus below 2**WIDTH never lets q escape the legal range.
  assign q_inc    = (q_q == QMAX) ? '0 : q_q + WIDTH'(1);
  assign q_dec    = (q_q == '0) ? QMAX : q_q - WIDTH'(1);
  assign load_val = (data_q > QMAX) ? QMAX : data_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    op_d      = op_q;
    data_d    = data_q;
    wrap_d    = 1'b0;
    j_drv     = '0;
    k_drv     = '0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    step_wrap = 1'b0;
    q_target  = q_q;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
            state_d = S_EXEC;
          end else if (cmd_data != '0) begin
            state_d = S_STEP;
            rem_d   = cmd_data;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_EXEC: begin
        if (op_q == OP_CLEAR) begin
          k_drv = '1;
        end else begin
          j_drv = load_val;
          k_drv = ~load_val;
        end
        state_d = S_DONE;
      end

      S_STEP: begin
        if (op_q == OP_DOWN) begin
          q_target  = q_dec;
          step_wrap = (q_q == '0);
        end else begin
          q_target  = q_inc;
          step_wrap = (q_q == QMAX);
        end
        // Toggling exactly the bits that differ moves q to the target.
        j_drv  = q_q ^ q_target;
        k_drv  = q_q ^ q_target;
        wrap_d = step_wrap;
        rem_d  = rem_q - WIDTH'(1);
        if (rem_q == WIDTH'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    q_d = (j_drv & ~q_q) | (~k_drv & q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      data_q  <= data_d;
      wrap_q  <= wrap_d;
    end
  end

  assign j    = j_drv;
  assign k    = k_drv;
  assign q    = q_q;
  assign busy = (state_q != S_IDLE);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed bench for jk_count_sequencer: a MOD=16 and a MOD=10 instance receive
// the same command stream and are checked against hand-computed values.
module tb_jk_count_sequencer;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;

  logic [3:0] j16, k16, q16, j10, k10, q10;
  logic       rdy16, busy16, done16, wrap16;
  logic       rdy10, busy10, done10, wrap10;

  jk_count_sequencer #(.WIDTH(4), .MOD(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy16),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .j(j16), .k(k16), .q(q16),
    .busy(busy16), .done(done16), .wrap(wrap16)
  );

  jk_count_sequencer #(.WIDTH(4), .MOD(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy10),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .j(j10), .k(k10), .q(q10),
    .busy(busy10), .done(done10), .wrap(wrap10)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Per-cycle capture, index i sampled after the i-th edge following accept.
  logic [3:0] rq10[16], rq16[16], rj10[16], rk10[16], rj16[16], rk16[16];
  logic       rw10[16], rw16[16], rd10[16], rd16[16], rb10[16], rr10[16];

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input int len);
    @(negedge clk);
    chk("ready_before_cmd", rdy10, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rq10[i] = q10;  rq16[i] = q16;
      rj10[i] = j10;  rk10[i] = k10;
      rj16[i] = j16;  rk16[i] = k16;
      rw10[i] = wrap10; rw16[i] = wrap16;
      rd10[i] = done10; rd16[i] = done16;
      rb10[i] = busy10; rr10[i] = rdy10;
    end
  endtask

  int up_q10[6] = '{8, 9, 0, 1, 2, 2};
  int up_q16[6] = '{8, 9, 10, 11, 12, 12};
  int up_w10[6] = '{0, 0, 1, 0, 0, 0};
  int up_d[6]   = '{0, 0, 0, 0, 1, 0};
  int dn_q10[5] = '{1, 0, 9, 8, 8};
  int dn_q16[5] = '{1, 0, 15, 14, 14};
  int dn_w10[5] = '{0, 0, 1, 0, 0};
  int dn_d[5]   = '{0, 0, 0, 1, 0};

  logic [1:0] b2b_op[4]   = '{OP_LOAD, OP_UP, OP_DOWN, OP_LOAD};
  logic [3:0] b2b_data[4] = '{4'd15, 4'd2, 4'd1, 4'd5};
  int b2b_cyc[4] = '{0, 3, 7, 10};
  int b2b_q10[4] = '{0, 9, 1, 0};
  int b2b_q16[4] = '{0, 15, 1, 0};
  int acc_cyc[4], acc_q10[4], acc_q16[4];
  int n_acc, n_done, n_w10, n_w16;

  initial begin
    // reset state, while rst_n is still low
    #3;
    chk("rst_q16", q16, 0);
    chk("rst_q10", q10, 0);
    chk("rst_ready", rdy16, 1);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_wrap", wrap10, 0);
    chk("rst_j", j16, 0);
    chk("rst_k", k10, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort mid-STEP with an asynchronous reset
    run_cmd(OP_LOAD, 4'd3, 3);
    chk("t1_load3", rq10[1], 3);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_step_start_q", q10, 3);
    @(negedge clk);
    chk("t1_step1_q", q10, 4);
    @(negedge clk);
    chk("t1_step2_q", q16, 5);
    chk("t1_busy_before_rst", busy16, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_q16", q16, 0);
    chk("t1_rst_q10", q10, 0);
    chk("t1_rst_ready", rdy10, 1);
    chk("t1_rst_busy", busy10, 0);
    chk("t1_rst_done", done10, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD 9 from q=0
    run_cmd(OP_LOAD, 4'd9, 3);
    chk("t2_exec_j16", rj16[0], 9);
    chk("t2_exec_k16", rk16[0], 6);
    chk("t2_exec_j10", rj10[0], 9);
    chk("t2_exec_k10", rk10[0], 6);
    chk("t2_exec_q", rq16[0], 0);
    chk("t2_exec_busy", rb10[0], 1);
    chk("t2_exec_ready", rr10[0], 0);
    chk("t2_exec_done", rd16[0], 0);
    chk("t2_q16", rq16[1], 9);
    chk("t2_q10", rq10[1], 9);
    chk("t2_done", rd16[1], 1);
    chk("t2_wrap", rw16[1], 0);
    chk("t2_done_end", rd16[2], 0);
    chk("t2_idle_ready", rr10[2], 1);

    // LOAD 8 then UP 4
    run_cmd(OP_LOAD, 4'd8, 3);
    run_cmd(OP_UP, 4'd4, 6);
    chk("t3_j10_step0", rj10[0], 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_q10[%0d]", i), rq10[i], up_q10[i]);
      chk($sformatf("t3_q16[%0d]", i), rq16[i], up_q16[i]);
      chk($sformatf("t3_wrap10[%0d]", i), rw10[i], up_w10[i]);
      chk($sformatf("t3_wrap16[%0d]", i), rw16[i], 0);
      chk($sformatf("t3_done[%0d]", i), rd10[i], up_d[i]);
    end

    // LOAD 1 then DOWN 3
    run_cmd(OP_LOAD, 4'd1, 3);
    run_cmd(OP_DOWN, 4'd3, 5);
    chk("t4_j10_1to0", rj10[0], 1);
    chk("t4_j10_0to9", rj10[1], 9);
    chk("t4_k10_0to9", rk10[1], 9);
    chk("t4_j16_0to15", rj16[1], 15);
    chk("t4_j10_9to8", rj10[2], 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_q10[%0d]", i), rq10[i], dn_q10[i]);
      chk($sformatf("t4_q16[%0d]", i), rq16[i], dn_q16[i]);
      chk($sformatf("t4_wrap10[%0d]", i), rw10[i], dn_w10[i]);
      chk($sformatf("t4_wrap16[%0d]", i), rw16[i], dn_w10[i]);
      chk($sformatf("t4_done[%0d]", i), rd16[i], dn_d[i]);
    end

    // UP n=0 and CLEAR from q=7
    run_cmd(OP_LOAD, 4'd7, 3);
    run_cmd(OP_UP, 4'd0, 2);
    chk("t5_n0_done", rd10[0], 1);
    chk("t5_n0_q10", rq10[0], 7);
    chk("t5_n0_q16", rq16[0], 7);
    chk("t5_n0_wrap", rw10[0], 0);
    chk("t5_n0_idle", rb10[1], 0);
    run_cmd(OP_CLEAR, 4'd6, 3);
    chk("t5_clr_j10", rj10[0], 0);
    chk("t5_clr_k10", rk10[0], 15);
    chk("t5_clr_k16", rk16[0], 15);
    chk("t5_clr_q_exec", rq10[0], 7);
    chk("t5_clr_q10", rq10[1], 0);
    chk("t5_clr_q16", rq16[1], 0);
    chk("t5_clr_done", rd16[1], 1);
    chk("t5_clr_wrap", rw10[1], 0);

    // back-to-back with cmd_valid held high
    n_acc = 0; n_done = 0; n_w10 = 0; n_w16 = 0;
    for (int i = 0; i < 4; i++) begin
      acc_cyc[i] = -1; acc_q10[i] = -1; acc_q16[i] = -1;
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (done10) n_done++;
      if (wrap10) n_w10++;
      if (wrap16) n_w16++;
      if (n_acc < 4) begin
        cmd_valid = 1'b1;
        cmd_op    = b2b_op[n_acc];
        cmd_data  = b2b_data[n_acc];
        if (rdy10) begin
          acc_cyc[n_acc] = cyc;
          acc_q10[n_acc] = int'(q10);
          acc_q16[n_acc] = int'(q16);
          n_acc++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("t6_accepts", n_acc, 4);
    chk("t6_dones", n_done, 4);
    chk("t6_wraps10", n_w10, 1);
    chk("t6_wraps16", n_w16, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_acc_cyc[%0d]", i), acc_cyc[i], b2b_cyc[i]);
      chk($sformatf("t6_acc_q10[%0d]", i), acc_q10[i], b2b_q10[i]);
      chk($sformatf("t6_acc_q16[%0d]", i), acc_q16[i], b2b_q16[i]);
    end
    chk("t6_final_q10", q10, 5);
    chk("t6_final_q16", q16, 5);
    chk("t6_final_ready", rdy16, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
